// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared command opcodes, controller states and ALU function codes
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_ALU_OP     = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP_OP = 8'hDD;

  localparam logic [3:0] ALU_FUN_ADD = 4'h0;
  localparam logic [3:0] ALU_FUN_SUB = 4'h1;
  localparam logic [3:0] ALU_FUN_MUL = 4'h2;
  localparam logic [3:0] ALU_FUN_DIV = 4'h3;
  localparam logic [3:0] ALU_FUN_AND = 4'h4;
  localparam logic [3:0] ALU_FUN_OR  = 4'h5;
  localparam logic [3:0] ALU_FUN_XOR = 4'h6;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    WAIT_RES,
    TX_LO,
    TX_HI
  } ctrl_state_t;

endpackage

// File: rtl/sys_alu_ctrl_if.sv
// rtl/sys_alu_ctrl_if.sv - receive, ALU and transmit signals between the controller and its peers
interface sys_alu_ctrl_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]   RX_DATA;
  logic                    RX_VALID;
  logic [DATA_WIDTH-1:0]   ALU_A;
  logic [DATA_WIDTH-1:0]   ALU_B;
  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic [RESULT_WIDTH-1:0] ALU_OUT;
  logic                    ALU_VALID;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VALID;
  logic                    TX_READY;
  logic                    BUSY;
  logic                    ERR;

  modport master (
    input  RX_DATA, RX_VALID, ALU_OUT, ALU_VALID, TX_READY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR
  );

  modport slave (
    output RX_DATA, RX_VALID, ALU_OUT, ALU_VALID, TX_READY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR
  );

endinterface

// File: rtl/sys_alu_tx_ser.sv
// rtl/sys_alu_tx_ser.sv - loads one result word and streams it out low byte first
module sys_alu_tx_ser #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word_tdata,
  input  logic                  word_tvalid,
  output logic [DATA_WIDTH-1:0] byte_tdata,
  output logic                  byte_tvalid,
  input  logic                  byte_tready
);

  logic [WORD_WIDTH-1:0] word_q;
  logic                  valid_q;
  logic                  hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
    end else if (word_tvalid) begin
      word_q  <= word_tdata;
      valid_q <= 1'b1;
      hi_q    <= 1'b0;
    end else if (valid_q && byte_tready) begin
      if (hi_q) begin
        valid_q <= 1'b0;
        hi_q    <= 1'b0;
      end else begin
        hi_q <= 1'b1;
      end
    end
  end

  // Output bus idles at zero so nothing stale is visible between words.
  always_comb begin
    byte_tdata = '0;
    if (valid_q) begin
      byte_tdata = hi_q ? word_q[WORD_WIDTH-1 -: DATA_WIDTH] : word_q[DATA_WIDTH-1:0];
    end
  end

  assign byte_tvalid = valid_q;

endmodule

// File: rtl/sys_alu_ctrl.sv
// rtl/sys_alu_ctrl.sv - parses command frames, drives the ALU and returns its result as two bytes
module sys_alu_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 15
) (
  input  logic           CLK,
  input  logic           RST,
  sys_alu_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  ctrl_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]            alu_fun_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  res_load;
  logic                  timeout_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GET_A && bus.RX_VALID) alu_a_q <= bus.RX_DATA;
      if (state_q == GET_B && bus.RX_VALID) alu_b_q <= bus.RX_DATA;
      if (state_q == GET_FUN && bus.RX_VALID) alu_fun_q <= bus.RX_DATA[3:0];
      // Held at zero outside WAIT_RES, so every entry starts counting from zero.
      if (state_q != WAIT_RES) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    res_load    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d = GET_A;
          end else if (bus.RX_DATA == DATA_WIDTH'(CMD_ALU_NOP_OP)) begin
            state_d = GET_FUN;
          end
        end
      end
      GET_A:   if (bus.RX_VALID) state_d = GET_B;
      GET_B:   if (bus.RX_VALID) state_d = GET_FUN;
      GET_FUN: if (bus.RX_VALID) state_d = WAIT_RES;
      WAIT_RES: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (bus.ALU_VALID) begin
          res_load = 1'b1;
          state_d  = TX_LO;
        end else if (cnt_q == CNT_MAX) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      TX_LO:   if (bus.TX_READY) state_d = TX_HI;
      TX_HI:   if (bus.TX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sys_alu_tx_ser #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (RESULT_WIDTH)
  ) u_tx_ser (
    .clk         (CLK),
    .rst         (RST),
    .word_tdata  (bus.ALU_OUT),
    .word_tvalid (res_load),
    .byte_tdata  (bus.TX_DATA),
    .byte_tvalid (bus.TX_VALID),
    .byte_tready (bus.TX_READY)
  );

  assign bus.ALU_A   = alu_a_q;
  assign bus.ALU_B   = alu_b_q;
  assign bus.ALU_FUN = alu_fun_q;
  assign bus.ALU_EN  = (state_q == WAIT_RES);
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.ERR     = timeout_hit;

endmodule

// File: tb/tb_sys_alu_ctrl.sv
// tb/tb_sys_alu_ctrl.sv - scoreboard bench for sys_alu_ctrl with a registered ALU model
module tb_sys_alu_ctrl;
  import sys_ctrl_pkg::*;

  localparam int TIMEOUT = 15;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sys_alu_ctrl_if #(.DATA_WIDTH(8), .RESULT_WIDTH(16)) bus ();

  sys_alu_ctrl #(
    .DATA_WIDTH   (8),
    .RESULT_WIDTH (16),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      ALU_FUN_ADD: return 16'(a) + 16'(b);
      ALU_FUN_SUB: return 16'(a) - 16'(b);
      ALU_FUN_MUL: return 16'(a) * 16'(b);
      ALU_FUN_DIV: return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
      ALU_FUN_AND: return 16'(a & b);
      ALU_FUN_OR:  return 16'(a | b);
      ALU_FUN_XOR: return 16'(a ^ b);
      default:     return {a, b};
    endcase
  endfunction

  // Registered ALU: answers alu_lat cycles after it first samples ALU_EN high.
  bit alu_on  = 1'b1;
  int alu_lat = 0;
  int en_cnt;
  always @(posedge CLK) begin
    if (RST || !bus.ALU_EN) begin
      bus.ALU_VALID <= 1'b0;
      if (RST) bus.ALU_OUT <= '0;
      en_cnt <= 0;
    end else begin
      en_cnt        <= en_cnt + 1;
      bus.ALU_VALID <= alu_on && (en_cnt >= alu_lat);
      bus.ALU_OUT   <= alu_ref(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
    end
  end

  logic [7:0]  exp_q[$];
  logic [19:0] op_q[$];
  logic [7:0]  a_m = 8'h00;
  logic [7:0]  b_m = 8'h00;
  int err_exp  = 0;
  int err_seen = 0;
  int tx_count = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_en    = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (RST) begin
      prev_stall = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (prev_stall) check("tx_hold", {bus.TX_VALID, bus.TX_DATA}, {1'b1, prev_data});
      if (bus.TX_VALID && bus.TX_READY) begin
        tx_count++;
        if (exp_q.size() == 0) check("tx_unexpected", {bus.TX_VALID, bus.TX_DATA}, 32'h0);
        else check("tx_byte", bus.TX_DATA, exp_q.pop_front());
      end
      if (bus.ALU_EN && !prev_en) begin
        if (op_q.size() == 0) check("alu_en_unexpected", bus.ALU_EN, 32'h0);
        else check("alu_a_b_fun", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN}, op_q.pop_front());
      end
      if (bus.ERR) err_seen++;
      prev_stall = bus.TX_VALID && !bus.TX_READY;
      prev_data  = bus.TX_DATA;
      prev_en    = bus.ALU_EN;
    end
  end

  function automatic logic [7:0] junk();
    logic [7:0] v;
    do v = 8'($urandom); while (v == CMD_ALU_OP || v == CMD_ALU_NOP_OP);
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] v);
    @(posedge CLK); #1;
    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = v;
    @(posedge CLK); #1;
    bus.RX_VALID = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] f, input bit on, input int lat);
    logic [15:0] r;
    alu_on  = on;
    alu_lat = lat;
    if (cmd == CMD_ALU_OP) begin
      a_m = a;
      b_m = b;
    end
    op_q.push_back({a_m, b_m, f[3:0]});
    if (on && (lat + 1 <= TIMEOUT)) begin
      r = alu_ref(a_m, b_m, f[3:0]);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
    end else begin
      err_exp++;
    end
    send_byte(cmd);
    if (cmd == CMD_ALU_OP) begin
      send_byte(a);
      send_byte(b);
    end
    send_byte(f);
  endtask

  task automatic wait_idle(input bit noisy);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK); #1;
      if (!bus.BUSY) begin
        done = 1'b1;
      end else if (noisy) begin
        bus.TX_READY = ($urandom_range(0, 2) != 0);
        bus.RX_VALID = ($urandom_range(0, 3) == 0);
        bus.RX_DATA  = junk();
      end
    end
    bus.RX_VALID = 1'b0;
    bus.TX_READY = 1'b1;
    if (!done) check("wait_idle_timeout", bus.BUSY, 32'h0);
  endtask

  task automatic wait_tx_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (bus.TX_VALID) seen = 1'b1;
    end
    if (!seen) check("wait_tx_valid_timeout", bus.TX_VALID, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, bus.ALU_A, 32'h0);
    check({tag, "_alu_b"}, bus.ALU_B, 32'h0);
    check({tag, "_alu_fun"}, bus.ALU_FUN, 32'h0);
    check({tag, "_alu_en"}, bus.ALU_EN, 32'h0);
    check({tag, "_tx_valid"}, bus.TX_VALID, 32'h0);
    check({tag, "_tx_data"}, bus.TX_DATA, 32'h0);
    check({tag, "_busy"}, bus.BUSY, 32'h0);
    check({tag, "_err"}, bus.ERR, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tx_before;
    RST          = 1'b1;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
    bus.TX_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    // ADD with minimum latency: result bytes at t+2 and t+3, idle at t+4.
    run_frame(CMD_ALU_OP, 8'h14, 8'h0A, {4'h0, ALU_FUN_ADD}, 1'b1, 0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      check($sformatf("add_alu_en_k%0d", k), bus.ALU_EN, 32'(k <= 1));
      check($sformatf("add_tx_valid_k%0d", k), bus.TX_VALID, 32'(k == 2 || k == 3));
      check($sformatf("add_busy_k%0d", k), bus.BUSY, 32'(k <= 3));
    end
    check("add_tx_hi_byte_seen", tx_count, 32'd2);

    // MUL with the transmit side stalled for three cycles on the low byte.
    bus.TX_READY = 1'b0;
    run_frame(CMD_ALU_OP, 8'hFF, 8'hFF, {4'hA, ALU_FUN_MUL}, 1'b1, 0);
    wait_tx_valid();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge CLK);
      check($sformatf("mul_stall_data_k%0d", k), bus.TX_DATA, 32'h01);
    end
    @(posedge CLK); #1;
    bus.TX_READY = 1'b1;
    wait_idle(1'b0);

    // Short frame reuses A/B = FF/FF.
    run_frame(CMD_ALU_NOP_OP, 8'h00, 8'h00, {4'h0, ALU_FUN_SUB}, 1'b1, 0);
    wait_idle(1'b0);

    // ALU never answers: single ERR pulse exactly TIMEOUT cycles after ALU_EN rises.
    run_frame(CMD_ALU_OP, 8'h05, 8'h03, {4'h0, ALU_FUN_ADD}, 1'b0, 0);
    for (int k = 0; k <= TIMEOUT + 1; k++) begin
      @(negedge CLK);
      check($sformatf("to_err_k%0d", k), bus.ERR, 32'(k == TIMEOUT));
      if (k >= TIMEOUT - 1) check($sformatf("to_alu_en_k%0d", k), bus.ALU_EN, 32'(k <= TIMEOUT));
      check($sformatf("to_tx_valid_k%0d", k), bus.TX_VALID, 32'h0);
    end
    check("to_idle_after", bus.BUSY, 32'h0);

    // Result on the last allowed cycle wins; one cycle later it loses.
    run_frame(CMD_ALU_OP, 8'h30, 8'h07, {4'h0, ALU_FUN_OR}, 1'b1, TIMEOUT - 1);
    wait_idle(1'b0);
    run_frame(CMD_ALU_OP, 8'h31, 8'h08, {4'h0, ALU_FUN_AND}, 1'b1, TIMEOUT);
    wait_idle(1'b0);

    // Junk in IDLE and extra bytes during TX_LO are dropped.
    send_byte(8'h12);
    send_byte(8'hAB);
    tx_before    = tx_count;
    bus.TX_READY = 1'b0;
    run_frame(CMD_ALU_OP, 8'h21, 8'h10, {4'h0, ALU_FUN_XOR}, 1'b1, 0);
    wait_tx_valid();
    send_byte(CMD_ALU_OP);
    send_byte(8'h33);
    bus.TX_READY = 1'b1;
    wait_idle(1'b0);
    repeat (3) @(posedge CLK);
    check("junk_tx_count", tx_count - tx_before, 32'd2);

    // Reset while the high byte is pending.
    bus.TX_READY = 1'b0;
    run_frame(CMD_ALU_OP, 8'h40, 8'h02, {4'h0, ALU_FUN_MUL}, 1'b1, 0);
    wait_tx_valid();
    @(posedge CLK); #1;
    bus.TX_READY = 1'b1;
    @(posedge CLK); #1;
    bus.TX_READY = 1'b0;
    RST = 1'b1;
    exp_q.delete();
    a_m = 8'h00;
    b_m = 8'h00;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid_tx_reset");
    bus.TX_READY = 1'b1;
    run_frame(CMD_ALU_OP, 8'h09, 8'h04, {4'h0, ALU_FUN_SUB}, 1'b1, 0);
    wait_idle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] cmd;
      int n_junk;
      n_junk = $urandom_range(0, 2);
      for (int j = 0; j < n_junk; j++) send_byte(junk());
      cmd = ($urandom_range(0, 3) == 0) ? CMD_ALU_NOP_OP : CMD_ALU_OP;
      run_frame(cmd, 8'($urandom), 8'($urandom), {4'($urandom), 4'($urandom_range(0, 7))},
                ($urandom_range(0, 7) != 0), $urandom_range(0, 3));
      wait_idle(1'b1);
    end

    repeat (4) @(posedge CLK);
    check("final_tx_queue_empty", exp_q.size(), 32'h0);
    check("final_op_queue_empty", op_q.size(), 32'h0);
    check("final_err_count", err_seen, err_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_alu_ctrl.md
# sys_alu_ctrl

Command-side controller that drives the ALU and returns its result. It parses a byte stream from the receive path into ALU operations, presents operands and function to the ALU, and waits for the ALU's valid flag. It then serialises the 16-bit result as two bytes to the transmit path. It sits between the UART receive/transmit data paths and the ALU inside the system-control domain.

## Interface
Parameters:
- DATA_WIDTH, 8, operand and byte width
- RESULT_WIDTH, 16, ALU result width (must equal 2*DATA_WIDTH)
- TIMEOUT, 15, max cycles to wait for ALU valid before abort

Ports:
- CLK  in  1  system clock; one clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_DATA  in  DATA_WIDTH  received byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- ALU_A  out  DATA_WIDTH  operand A (registered)
- ALU_B  out  DATA_WIDTH  operand B (registered)
- ALU_FUN  out  4  ALU function code (registered)
- ALU_EN  out  1  ALU enable
- ALU_OUT  in  RESULT_WIDTH  ALU result
- ALU_VALID  in  1  ALU result valid
- TX_DATA  out  DATA_WIDTH  result byte
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  transmit path accepts byte
- BUSY  out  1  high in any state other than IDLE
- ERR  out  1  one-cycle pulse on ALU timeout

## Operation
- Frame 0xCC: command byte, then A, then B, then FUN byte (low nibble used, high nibble ignored).
- Frame 0xDD: command byte, then FUN byte. Reuses the stored A/B from the last 0xCC frame (0x00/0x00 after reset).
- States: IDLE, GET_A, GET_B, GET_FUN, WAIT_RES, TX_LO, TX_HI.
- IDLE transitions:
  - RX_VALID with 0xCC → GET_A.
  - RX_VALID with 0xDD → GET_FUN.
  - Any other byte is ignored and the state stays IDLE.
- Byte capture:
  - GET_A loads ALU_A on RX_VALID, then → GET_B.
  - GET_B loads ALU_B on RX_VALID, then → GET_FUN.
  - GET_FUN loads ALU_FUN on RX_VALID, then → WAIT_RES.
  - Without RX_VALID, each GET state holds indefinitely; there is no inter-byte timeout.
- WAIT_RES:
  - ALU_EN is held high.
  - The cycle counter increments each cycle.
  - On ALU_VALID: capture ALU_OUT into the result register, then → TX_LO.
  - If the counter reaches TIMEOUT without ALU_VALID: pulse ERR, → IDLE, nothing is transmitted.
- TX_LO: TX_DATA = result[7:0], TX_VALID=1. On TX_READY → TX_HI.
- TX_HI: TX_DATA = result[15:8], TX_VALID=1. On TX_READY → IDLE.
- Byte-level rules:
  - A transfer occurs when TX_VALID and TX_READY are both high.
  - TX_DATA stays stable while TX_VALID=1 and TX_READY=0.
  - RX bytes arriving in WAIT_RES, TX_LO or TX_HI are dropped and not buffered.
  - ALU_VALID outside WAIT_RES is ignored.

## Timing
- Reset values: ALU_A, ALU_B, ALU_FUN = 0; ALU_EN, TX_VALID, BUSY, ERR = 0; TX_DATA = 0x00; state = IDLE; counter = 0.
- Reset mid-frame or mid-transmit: on the next edge the state is IDLE and TX_VALID=0. The partial frame and pending result are discarded.
- FUN byte accepted at edge t: ALU_EN=1 from t+1. With a registered ALU, ALU_VALID arrives at t+2 and the result is captured at that edge. TX_VALID=1 from t+2 onward (low byte).
- Minimum frame-to-last-byte latency with TX_READY tied high: 2 TX cycles after capture. The controller returns to IDLE and can accept the next command byte in the following cycle.
- ALU_VALID in the same cycle the counter reaches TIMEOUT: the result wins; no ERR is raised.
- The counter clears on entry to WAIT_RES. Its width is clog2(TIMEOUT+1).
- ALU_EN drops in the cycle after ALU_VALID or timeout.

## Structure
- Shared package sys_ctrl_pkg holds:
  - opcode constants CMD_ALU_OP = 8'hCC and CMD_ALU_NOP_OP = 8'hDD;
  - the state enum;
  - ALU function-code constants, shared with the ALU decoder.
- One sub-module, sys_alu_tx_ser: two-byte valid/ready serialiser that loads a 16-bit word and emits the low byte then the high byte. The FSM, operand registers and timeout counter stay in the top.

## Test plan
- 0xCC,0x14,0x0A,0x00 (ADD), ALU returns 0x001E at t+2 → ALU_A=0x14, ALU_B=0x0A, ALU_FUN=0; TX bytes 0x1E then 0x00; BUSY low afterwards.
- 0xCC,0xFF,0xFF,0x02 (MUL), ALU returns 0xFE01, TX_READY held low 3 cycles → TX_DATA=0x01 stable for those 3 cycles, then 0x01 and 0xFE transfer in order.
- After the previous case, 0xDD,0x01 (SUB), ALU returns 0x0000 → ALU_A/B remain 0xFF/0xFF, ALU_FUN=1, TX bytes 0x00,0x00.
- 0xCC,0x05,0x03,0x00 with ALU_VALID never asserted → ERR high exactly one cycle TIMEOUT cycles after ALU_EN rises; no TX_VALID; IDLE afterwards.
- Junk bytes 0x12,0xAB in IDLE, then a valid 0xCC frame; extra bytes sent during TX_LO → junk and extra bytes ignored; exactly two TX bytes for the valid frame.
- RST asserted during TX_HI → TX_VALID=0 and all outputs at reset values on the next edge; the next 0xCC frame runs normally.
